load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  MEM-stage controller sitting directly upstream of data_memory. It takes one load/store request
//  from the pipeline and drives data_memory's addr/wr/r/data_in, capturing data_out.
//  Memory is big-endian: byte at addr lands in data_out[31:24], and every write stores 4 bytes.
//  Hence SB/SH need a read-modify-write sequence. Loads are sign- or zero-extended here.
//  Returns one response per request, including the writeback register tag.
// PARAMETERS
//  ADDR_W      12  data_memory byte-address width (4 KB)
//  EA_W        32  effective-address width from the ALU
//  CHECK_RANGE 1   1: nonzero ea[EA_W-1:ADDR_W] flags addr_err; 0: upper bits ignored
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       1 only in IDLE; request accepted on edge with req_valid&req_ready
//  req_op      in   3       000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
//  req_ea      in   EA_W    effective byte address
//  req_wdata   in   32      store data; SB uses [7:0], SH uses [15:0]
//  req_tag     in   5       destination register; echoed on resp_tag
//  resp_valid  out  1       one-cycle response pulse
//  resp_rdata  out  32      extended load data; 0 for stores and errors
//  resp_tag    out  5       latched req_tag
//  resp_err    out  1       misaligned or out-of-range; memory not accessed
//  mem_addr    out  ADDR_W  to data_memory addr
//  mem_wr      out  1       to data_memory wr
//  mem_r       out  1       to data_memory r
//  mem_wdata   out  32      to data_memory data_in
//  mem_rdata   in   32      from data_memory data_out; Z when mem_r=0
// BEHAVIOUR
//  Reset
//   - State is IDLE.
//   - resp_valid=0, resp_err=0, resp_rdata=0, resp_tag=0.
//   - mem_wr=0, mem_r=0, mem_addr=0, mem_wdata=0.
//   - req_ready=1 from the first cycle after reset.
//  Mid-operation reset aborts with no response. A write cycle that was already driving is cut.
//  States and transitions: IDLE, RD, WR, RESP. Edge E0 is the accept edge.
//   - Error (LH/LHU/SH with ea[0]!=0, LW/SW with ea[1:0]!=0, or range fail): IDLE->RESP at E0.
//     resp_err=1 and there is no memory access.
//   - Load: IDLE->RD->RESP. mem_r=1 during the RD cycle; mem_rdata is sampled at E1.
//     resp_valid is high in the cycle after E1, so latency is 2 edges.
//   - SW: IDLE->WR->RESP. mem_wr=1 for exactly the WR cycle with mem_wdata=req_wdata.
//   - SB/SH: IDLE->RD->WR->RESP. The RD sample is merged into wbuf:
//       SB wbuf = {wdata[7:0], rd[23:0]};  SH wbuf = {wdata[15:0], rd[15:0]}.
//     wbuf is then written in WR. Latency is 3 edges.
//   - RESP->IDLE unconditionally. At most 1 request in flight, with no back-to-back accept.
//  Output rules
//   - mem_r and mem_wr are never both 1, and both are 0 in IDLE and RESP.
//   - mem_addr and mem_wdata are registered and stable for the whole strobe cycle.
//  Load extension
//   - LB: sign-extend rd[31:24].  LBU: zero-extend rd[31:24].
//   - LH: sign-extend rd[31:16].  LHU: zero-extend rd[31:16].  LW: rd.
//  Wrap-around: mem_addr=ea[ADDR_W-1:0]; memory-side addr+1..+3 wrap modulo 2^ADDR_W.
//   SB at 0xFFF rewrites 0x000..0x002 with the values just read, so those bytes are unchanged.
//  req_* inputs are sampled only at the accept edge and ignored otherwise.
// STRUCTURE
//  - Package mips_mem_pkg: op encodings (LSU_LB..LSU_SW) and the lsu_state_t enum
//    {IDLE, RD, WR, RESP}. Also is_load/is_store/is_sub_word helper functions.
//  - Sub-module lsu_align (combinational): op + raw word -> extended load data, merged store word,
//    misalign flag. The FSM and all registers stay in load_store_unit.
// TESTING
//  - Reset/idle: hold rst 3 cycles with req_valid=1 -> no strobes, resp_valid=0.
//    req_ready=1 on the first cycle after rst drops.
//  - SW 0xDEADBEEF @0x010, then LW @0x010 -> exactly 1 mem_wr cycle;
//    resp_rdata=0xDEADBEEF at 2 edges after accept.
//  - After that SW: LB @0x010 -> 0xFFFFFFDE; LBU @0x011 -> 0x000000AD;
//    LH @0x012 -> 0xFFFFBEEF; LHU @0x010 -> 0x0000DEAD.
//  - SB 0x55 @0x011, then LW @0x010 -> 0xDE55BEEF. Check RD then WR strobes, with 3-edge latency.
//  - Misaligned LW @0x012, SH @0x013, and ea=0x1000 with CHECK_RANGE=1 -> resp_err=1,
//    resp_rdata=0, no mem_r/mem_wr, resp one edge after accept.
//  - Wrap: SW 0x11223344 @0xFFC, SB 0xAA @0xFFF -> LW @0xFFC = 0x112233AA; bytes 0x000..0x002
//    are unchanged. Also assert rst during the WR cycle: no resp, and mem_wr drops next edge.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: op encodings,
// controller states and op-classification helpers.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'b000,
        LSU_LH  = 3'b001,
        LSU_LW  = 3'b010,
        LSU_LBU = 3'b011,
        LSU_LHU = 3'b100,
        LSU_SB  = 3'b101,
        LSU_SH  = 3'b110,
        LSU_SW  = 3'b111
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
    endfunction

    function automatic logic is_store(lsu_op_t op);
        return op inside {LSU_SB, LSU_SH, LSU_SW};
    endfunction

    // Stores narrower than the 4-byte memory write; these need read-modify-write.
    function automatic logic is_sub_word(lsu_op_t op);
        return op inside {LSU_SB, LSU_SH};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit: extends big-endian
// load data, merges sub-word store data into the word just read, and flags
// misaligned halfword/word accesses.
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    lsu_op_t op_e;
    assign op_e = lsu_op_t'(op);

    // Byte at the access address sits in rd_word[31:24]; extend from there.
    always_comb begin
        load_data  = rd_word;
        store_word = wdata;
        misalign   = 1'b0;
        case (op_e)
            LSU_LB:  load_data = {{24{rd_word[31]}}, rd_word[31:24]};
            LSU_LBU: load_data = {24'h000000, rd_word[31:24]};
            LSU_LH:  load_data = {{16{rd_word[31]}}, rd_word[31:16]};
            LSU_LHU: load_data = {16'h0000, rd_word[31:16]};
            default: load_data = rd_word;
        endcase
        case (op_e)
            LSU_SB:  store_word = {wdata[7:0], rd_word[23:0]};
            LSU_SH:  store_word = {wdata[15:0], rd_word[15:0]};
            default: store_word = wdata;
        endcase
        case (op_e)
            LSU_LH, LSU_LHU, LSU_SH: misalign = ea_lo[0];
            LSU_LW, LSU_SW:          misalign = |ea_lo;
            default:                 misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller in front of a big-endian, 4-byte-write
// data memory. One request in flight; sub-word stores are read-modify-write.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned EA_W        = 32,
    parameter int unsigned CHECK_RANGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [EA_W-1:0]   req_ea,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_tag,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_tag,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_r,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t      state;
    lsu_state_t      state_next;
    lsu_op_t         op_q;
    lsu_op_t         req_op_e;
    lsu_op_t         align_op;
    logic [EA_W-1:0] ea_hi;
    logic            range_err;
    logic            misalign;
    logic            req_err;
    logic [31:0]     load_data;
    logic [31:0]     store_word;

    assign req_op_e  = lsu_op_t'(req_op);
    assign ea_hi     = req_ea >> ADDR_W;
    assign range_err = (CHECK_RANGE != 0) && (ea_hi != '0);

    // The aligner checks the incoming op while idle and the latched op afterwards.
    assign align_op = (state == IDLE) ? req_op_e : op_q;
    assign req_err  = misalign | range_err;

    // mem_wdata doubles as the store-data holding register: it captures
    // req_wdata at accept, and SB/SH merge from it before the write cycle.
    lsu_align u_align (
        .op         (align_op),
        .ea_lo      (req_ea[1:0]),
        .rd_word    (mem_rdata),
        .wdata      (mem_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and strobe/handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_r      = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (is_store(req_op_e) && !is_sub_word(req_op_e))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                mem_r      = 1'b1;
                state_next = is_sub_word(op_q) ? WR : RESP;
            end
            WR: begin
                mem_wr     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory address/data and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= LSU_LB;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op_e;
                        resp_tag   <= req_tag;
                        resp_err   <= req_err;
                        resp_rdata <= '0;
                        if (!req_err) begin
                            mem_addr  <= req_ea[ADDR_W-1:0];
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (is_load(op_q)) resp_rdata <= load_data;
                    else               mem_wdata  <= store_word;
                end
                default: ;
            endcase
        end
    end

endmodule
